// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one PsramController between CPU, video and DMA requesters.
// Build option: define PSRAM_ARB_AGING_EN to let a long-waiting video request outrank the CPU.
module psram_arbiter #(
  parameter int unsigned VID_MAX_WAIT  = 24,
  parameter int unsigned ISSUE_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [21:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic        cpu_byte,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [21:0] vid_addr,
  output logic        vid_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [21:0] dma_addr,
  input  logic [15:0] dma_din,
  output logic        dma_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        m_read,
  output logic        m_write,
  output logic        m_rdv,
  output logic [21:0] m_addr,
  output logic [15:0] m_din,
  output logic        m_byte,
  input  logic        m_busy,
  input  logic [31:0] m_dout
);

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 32;
  localparam int unsigned TW = $clog2(ISSUE_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_DMA} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  owner_t        pick_c;
  logic          wr_q, wr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] din_d;
  logic [RW-1:0] rdata_d;
  logic          byte_d, err_d;
  logic          read_d, write_d, rdv_d;
  logic          cpu_ack_d, vid_ack_d, dma_ack_d;
  logic          vid_aged_c;
  logic          vid_grant_c;

  assign vid_grant_c = (state_q == IDLE) && (pick_c == OWN_VID);

`ifdef PSRAM_ARB_AGING_EN
  // Video wait counter: saturates at VID_MAX_WAIT, cleared when video is granted.
  localparam int unsigned VW = $clog2(VID_MAX_WAIT + 1);
  logic [VW-1:0] vid_wait_q, vid_wait_d;

  always_comb begin
    vid_wait_d = vid_wait_q;
    if (vid_grant_c) begin
      vid_wait_d = '0;
    end else if (vid_req && (vid_wait_q < VW'(VID_MAX_WAIT))) begin
      vid_wait_d = vid_wait_q + VW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_wait_q <= '0;
    end else begin
      vid_wait_q <= vid_wait_d;
    end
  end

  assign vid_aged_c = vid_req && (vid_wait_q == VW'(VID_MAX_WAIT));
`else
  logic unused_aging_cfg;
  assign unused_aging_cfg = ^32'(VID_MAX_WAIT);
  assign vid_aged_c       = 1'b0;
`endif

  // Next-state, grant and registered-output logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    tmo_d     = tmo_q;
    addr_d    = m_addr;
    din_d     = m_din;
    byte_d    = m_byte;
    rdata_d   = rdata;
    err_d     = err;
    read_d    = 1'b0;
    write_d   = 1'b0;
    rdv_d     = 1'b0;
    cpu_ack_d = 1'b0;
    vid_ack_d = 1'b0;
    dma_ack_d = 1'b0;
    pick_c    = OWN_NONE;

    if (!m_busy) begin
      if (vid_aged_c)              pick_c = OWN_VID;
      else if (cpu_wr || cpu_rd)   pick_c = OWN_CPU;
      else if (vid_req)            pick_c = OWN_VID;
      else if (dma_req)            pick_c = OWN_DMA;
    end

    unique case (state_q)
      IDLE: begin
        owner_d = pick_c;
        tmo_d   = '0;
        unique case (pick_c)
          OWN_CPU: begin
            wr_d   = cpu_wr;
            addr_d = cpu_addr;
            din_d  = cpu_din;
            byte_d = cpu_byte;
          end
          OWN_VID: begin
            wr_d   = 1'b0;
            addr_d = vid_addr & ~AW'(3);
            din_d  = '0;
            byte_d = 1'b0;
          end
          OWN_DMA: begin
            wr_d   = dma_we;
            addr_d = dma_addr;
            din_d  = dma_din;
            byte_d = 1'b0;
          end
          default: ;
        endcase
        if (pick_c != OWN_NONE) begin
          state_d = ISSUE;
          write_d = wr_d;
          read_d  = !wr_d && (pick_c != OWN_VID);
          rdv_d   = (pick_c == OWN_VID);
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        tmo_d   = '0;
      end
      WAIT_BUSY: begin
        if (m_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(ISSUE_TIMEOUT - 1)) begin
          // Controller never acknowledged the strobe: flag it and release the owner.
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = ACK;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!m_busy) begin
          if (!wr_q) rdata_d = m_dout;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == ACK) && (state_q != ACK)) begin
      cpu_ack_d = (owner_q == OWN_CPU);
      vid_ack_d = (owner_q == OWN_VID);
      dma_ack_d = (owner_q == OWN_DMA);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      wr_q    <= 1'b0;
      tmo_q   <= '0;
      m_addr  <= '0;
      m_din   <= '0;
      m_byte  <= 1'b0;
      m_read  <= 1'b0;
      m_write <= 1'b0;
      m_rdv   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      dma_ack <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      tmo_q   <= tmo_d;
      m_addr  <= addr_d;
      m_din   <= din_d;
      m_byte  <= byte_d;
      m_read  <= read_d;
      m_write <= write_d;
      m_rdv   <= rdv_d;
      rdata   <= rdata_d;
      err     <= err_d;
      cpu_ack <= cpu_ack_d;
      vid_ack <= vid_ack_d;
      dma_ack <= dma_ack_d;
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: behavioural PsramController model plus an in-order ack scoreboard.
module tb_psram_arbiter;

  localparam int unsigned ISSUE_TIMEOUT = 4;
  localparam int unsigned VID_MAX_WAIT  = 24;

  typedef struct {
    logic [1:0]  who;
    logic        chk;
    logic [31:0] mask;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr, cpu_byte, cpu_ack;
  logic [21:0] cpu_addr;
  logic [15:0] cpu_din;
  logic        vid_req, vid_ack;
  logic [21:0] vid_addr;
  logic        dma_req, dma_we, dma_ack;
  logic [21:0] dma_addr;
  logic [15:0] dma_din;
  logic [31:0] rdata;
  logic        err;
  logic        m_read, m_write, m_rdv, m_byte, m_busy;
  logic [21:0] m_addr;
  logic [15:0] m_din;
  logic [31:0] m_dout;

  psram_arbiter #(.VID_MAX_WAIT(VID_MAX_WAIT), .ISSUE_TIMEOUT(ISSUE_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_byte(cpu_byte), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_ack(dma_ack),
    .rdata(rdata), .err(err),
    .m_read(m_read), .m_write(m_write), .m_rdv(m_rdv), .m_addr(m_addr),
    .m_din(m_din), .m_byte(m_byte), .m_busy(m_busy), .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  // Controller model: busy for busy_len cycles starting the cycle after a strobe.
  int          busy_len;
  int          busy_cnt;
  logic        no_busy, force_busy;
  logic [31:0] vid_data;
  logic [15:0] mem [0:255];

  assign m_busy = force_busy || (busy_cnt != 0);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt <= 0;
      m_dout   <= '0;
    end else begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if ((m_read || m_write || m_rdv) && !no_busy) busy_cnt <= busy_len;
      if (m_write) mem[m_addr[8:1]] <= m_din;
      if (m_read)  m_dout <= {16'h0, mem[m_addr[8:1]]};
      if (m_rdv)   m_dout <= vid_data;
    end
  end

  int          cyc = 0;
  int          n_strobe = 0;
  logic [1:0]  last_kind = '0;
  logic [21:0] last_addr = '0;
  logic [15:0] last_din = '0;
  logic        last_byte = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_read || m_write || m_rdv) begin
      n_strobe  <= n_strobe + 1;
      last_kind <= m_rdv ? 2'd3 : (m_write ? 2'd2 : 2'd1);
      last_addr <= m_addr;
      last_din  <= m_din;
      last_byte <= m_byte;
    end
  end

  int          n_checks, n_fail;
  exp_t        sb[$];
  logic        sb_bypass;
  logic        prev_busy;
  int          ack_total, ack_cyc, fall_cyc, strobe_cyc;
  exp_t        e_mon;
  logic [1:0]  who_mon;
  logic [2:0]  acks_mon, strb_mon;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ack(input logic [1:0] who, input logic chk, input logic [31:0] mask,
                            input logic [31:0] data);
    exp_t e;
    e.who = who; e.chk = chk; e.mask = mask; e.data = data;
    sb.push_back(e);
  endtask

  // Wait (bounded) for n acks, dropping each requester as its ack arrives.
  task automatic run_acks(input int n, input int budget, input string tag);
    int got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (cpu_ack) begin got++; cpu_rd = 1'b0; cpu_wr = 1'b0; end
      if (vid_ack) begin got++; vid_req = 1'b0; end
      if (dma_ack) begin got++; dma_req = 1'b0; end
    end
    #1;
    check(tag, 32'(got), 32'(n));
  endtask

  initial begin
    int s0, t0, cpu_n, vid_n, vid_at;
    reset = 1'b1;
    cpu_rd = 0; cpu_wr = 0; cpu_byte = 0; cpu_addr = '0; cpu_din = '0;
    vid_req = 0; vid_addr = '0; dma_req = 0; dma_we = 0; dma_addr = '0; dma_din = '0;
    busy_len = 3; no_busy = 0; force_busy = 0; vid_data = '0;
    sb_bypass = 0; prev_busy = 0; ack_total = 0; ack_cyc = 0; fall_cyc = 0; strobe_cyc = 0;
    n_checks = 0; n_fail = 0;

    // Monitor: ack exclusivity, strobe exclusivity, scoreboard pop on every ack.
    fork
      forever begin
        @(negedge clk);
        acks_mon = {cpu_ack, vid_ack, dma_ack};
        strb_mon = {m_read, m_write, m_rdv};
        if (prev_busy && !m_busy) fall_cyc = cyc;
        prev_busy = m_busy;
        if (strb_mon != 3'b000) begin
          strobe_cyc = cyc;
          check("strobe_onehot", 32'($countones(strb_mon)), 32'd1);
        end
        if (acks_mon != 3'b000) begin
          ack_total++;
          ack_cyc = cyc;
          check("ack_onehot", 32'($countones(acks_mon)), 32'd1);
          who_mon = cpu_ack ? 2'd1 : (vid_ack ? 2'd2 : 2'd3);
          if (!sb_bypass) begin
            if (sb.size() == 0) begin
              check("unexpected_ack", 32'(acks_mon), 32'd0);
            end else begin
              e_mon = sb.pop_front();
              check("ack_owner", 32'(who_mon), 32'(e_mon.who));
              if (e_mon.chk) check("ack_rdata", rdata & e_mon.mask, e_mon.data);
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_strobes", 32'({m_read, m_write, m_rdv}), 32'd0);
    check("rst_acks", 32'({cpu_ack, vid_ack, dma_ack}), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_maddr", 32'(m_addr), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // CPU word write, controller busy for 8 cycles.
    busy_len = 8; s0 = n_strobe;
    expect_ack(2'd1, 1'b0, '0, '0);
    cpu_wr = 1; cpu_addr = 22'h000102; cpu_din = 16'hBEEF; cpu_byte = 0;
    run_acks(1, 60, "wr_ack");
    check("wr_strobes", 32'(n_strobe - s0), 32'd1);
    check("wr_kind", 32'(last_kind), 32'd2);
    check("wr_addr", 32'(last_addr), 32'h102);
    check("wr_din", 32'(last_din), 32'hBEEF);
    check("wr_byte", 32'(last_byte), 32'd0);
    check("wr_ack_after_fall", 32'(ack_cyc - fall_cyc), 32'd1);

    // CPU read back.
    busy_len = 3; s0 = n_strobe;
    expect_ack(2'd1, 1'b1, 32'h0000FFFF, 32'h0000BEEF);
    cpu_rd = 1; cpu_addr = 22'h000102;
    run_acks(1, 40, "rd_ack");
    check("rd_strobes", 32'(n_strobe - s0), 32'd1);
    check("rd_kind", 32'(last_kind), 32'd1);

    // Video fetch, low address bits forced to zero.
    vid_data = 32'h11223344;
    expect_ack(2'd2, 1'b1, 32'hFFFFFFFF, 32'h11223344);
    vid_req = 1; vid_addr = 22'h000043;
    run_acks(1, 40, "vid_ack");
    check("vid_kind", 32'(last_kind), 32'd3);
    check("vid_addr", 32'(last_addr), 32'h40);

    // DMA write.
    expect_ack(2'd3, 1'b0, '0, '0);
    dma_req = 1; dma_we = 1; dma_addr = 22'h000010; dma_din = 16'h1234;
    run_acks(1, 40, "dma_wr_ack");
    check("dma_wr_kind", 32'(last_kind), 32'd2);
    check("dma_wr_din", 32'(last_din), 32'h1234);
    check("dma_wr_addr", 32'(last_addr), 32'h10);

    // All three at once: CPU, then video, then DMA.
    vid_data = 32'hCAFEF00D; s0 = n_strobe;
    expect_ack(2'd1, 1'b1, 32'h0000FFFF, 32'h0000BEEF);
    expect_ack(2'd2, 1'b1, 32'hFFFFFFFF, 32'hCAFEF00D);
    expect_ack(2'd3, 1'b1, 32'h0000FFFF, 32'h00001234);
    cpu_rd = 1; cpu_addr = 22'h000102;
    vid_req = 1; vid_addr = 22'h000080;
    dma_req = 1; dma_we = 0; dma_addr = 22'h000010;
    run_acks(3, 200, "three_acks");
    check("three_strobes", 32'(n_strobe - s0), 32'd3);
    check("three_sb_empty", 32'(sb.size()), 32'd0);

    // Controller held busy (init): request stays pending without a strobe.
    force_busy = 1; s0 = n_strobe;
    expect_ack(2'd1, 1'b1, 32'h0000FFFF, 32'h0000BEEF);
    cpu_rd = 1; cpu_addr = 22'h000102;
    repeat (200) @(negedge clk);
    check("init_no_strobe", 32'(n_strobe - s0), 32'd0);
    force_busy = 0;
    run_acks(1, 40, "init_ack");
    check("init_strobes", 32'(n_strobe - s0), 32'd1);

    // Continuous CPU reads competing with video.
    sb_bypass = 1; cpu_n = 0; vid_n = 0; vid_at = -1;
    cpu_rd = 1; cpu_addr = 22'h000102; vid_req = 1; vid_addr = 22'h000080;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (cpu_ack) cpu_n++;
      if (vid_ack) begin vid_n++; vid_req = 0; if (vid_at < 0) vid_at = i; end
    end
`ifdef PSRAM_ARB_AGING_EN
    check("aging_vid_served", 32'(vid_n), 32'd1);
    check("aging_vid_bound", 32'(vid_at <= 36), 32'd1);
`else
    check("starve_no_vid", 32'(vid_n), 32'd0);
    check("starve_cpu_ops", 32'(cpu_n >= 10), 32'd1);
`endif
    cpu_rd = 0;
    for (int i = 0; i < 40 && vid_req; i++) begin
      @(negedge clk);
      if (vid_ack) begin vid_n++; vid_req = 0; end
    end
    check("starve_vid_after", 32'(vid_n), 32'd1);
    repeat (15) @(negedge clk);
    sb_bypass = 0;

    // Controller never raises busy: err, ack with rdata 0.
    no_busy = 1;
    expect_ack(2'd1, 1'b1, 32'hFFFFFFFF, 32'h0);
    cpu_rd = 1; cpu_addr = 22'h000102;
    run_acks(1, 30, "tmo_ack");
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_latency", 32'(ack_cyc - strobe_cyc), 32'(ISSUE_TIMEOUT + 1));
    no_busy = 0;
    expect_ack(2'd1, 1'b1, 32'h0000FFFF, 32'h0000BEEF);
    cpu_rd = 1;
    run_acks(1, 40, "post_tmo_ack");
    check("err_sticky", 32'(err), 32'd1);

    // Reset in WAIT_DONE abandons the op.
    busy_len = 20;
    cpu_rd = 1; cpu_addr = 22'h000102;
    for (int i = 0; i < 20 && !m_busy; i++) @(negedge clk);
    check("rst_reached_busy", 32'(m_busy), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1;
    #1;
    check("rst_mid_outputs", 32'({cpu_ack, vid_ack, dma_ack, m_read, m_write, m_rdv}), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    cpu_rd = 0; t0 = ack_total; s0 = n_strobe;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (40) @(negedge clk);
    #1;
    check("rst_no_spurious_ack", 32'(ack_total - t0), 32'd0);
    check("rst_no_strobe", 32'(n_strobe - s0), 32'd0);
    busy_len = 3;
    expect_ack(2'd1, 1'b1, 32'h0000FFFF, 32'h0000BEEF);
    cpu_rd = 1;
    run_acks(1, 40, "rst_recover_ack");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/psram_arbiter.md
Name:
psram_arbiter

Overview:
- Shares the single PsramController between three requesters: CPU (word/byte read/write), video (32-bit aligned fetch via rdv) and DMA (word read/write, e.g. floppy/loader).
- Sits between the system bus and the controller.
- Accepts level requests, issues single-cycle strobes to the controller, tracks the outstanding owner, and returns data with a one-cycle ack.

Parameters:
- VID_MAX_WAIT, 24: cycles a pending video request may wait before it pre-empts the priority order (aging, see Optional Feature).
- ISSUE_TIMEOUT, 4: cycles to wait for m_busy to rise after a strobe before declaring the controller unresponsive.

Ports:
clk  in  1  system clock, same as controller clk
reset  in  1  asynchronous, active-high
cpu_rd  in  1  CPU read request, level, held until cpu_ack
cpu_wr  in  1  CPU write request, level, held until cpu_ack
cpu_addr  in  22  CPU byte address
cpu_din  in  16  CPU write data
cpu_byte  in  1  CPU byte write; addr[0] selects upper byte
cpu_ack  out  1  one-cycle pulse: CPU op complete, rdata valid this cycle for reads
vid_req  in  1  video 32-bit read request, level
vid_addr  in  22  video address, bits [1:0] ignored (forced 0)
vid_ack  out  1  one-cycle pulse: rdata[31:0] = {dout2,dout} valid
dma_req  in  1  DMA request, level
dma_we  in  1  DMA direction, 1 = write, sampled at grant
dma_addr  in  22  DMA byte address
dma_din  in  16  DMA write data (always full word)
dma_ack  out  1  one-cycle pulse: DMA op complete
rdata  out  32  shared read data; [15:0] valid on cpu_ack/dma_ack, [31:0] on vid_ack
err  out  1  sticky: strobe issued but m_busy never rose; cleared only by reset
m_read  out  1  controller read strobe, one cycle
m_write  out  1  controller write strobe, one cycle
m_rdv  out  1  controller video read strobe, one cycle
m_addr  out  22  controller address, registered at grant
m_din  out  16  controller write data, registered at grant
m_byte  out  1  controller byte_write, registered at grant
m_busy  in  1  controller busy (high during init/config and every op)
m_dout  in  32  {dout2,dout} from controller

Behaviour:
- Reset: all outputs 0, state IDLE, owner NONE, wait counter 0, err 0. Asserting reset mid-operation abandons the op with no ack; the controller is reset by the same source.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK.
- IDLE: when m_busy=0 and any request is pending, grant by fixed priority CPU > video > DMA (cpu_wr wins over cpu_rd if both are set). Register owner, address, data and byte flag, then go to ISSUE. Requests while m_busy=1 are held pending; no strobe is issued.
- ISSUE: exactly one of m_read/m_write/m_rdv is high for exactly this cycle. Video uses m_rdv only; CPU and DMA reads use m_read. Go to WAIT_BUSY.
- WAIT_BUSY: when m_busy=1, go to WAIT_DONE. If ISSUE_TIMEOUT cycles elapse without m_busy, set err, pulse the owner's ack with rdata=0, and return to IDLE.
- WAIT_DONE: on m_busy falling (m_busy=0), capture m_dout into rdata (reads only; rdata unchanged on writes) and go to ACK.
- ACK: the owner's ack is high for 1 cycle, then IDLE. Minimum grant-to-ack is 4 cycles plus controller latency; back-to-back grants are possible from the cycle after ACK.
- Owner rules:
  - A request dropped before grant is ignored.
  - A request dropped after grant still completes and is still acked.
  - The requester must deassert within 1 cycle of ack; a request still high in the IDLE after ACK is a new request.
- Acks are mutually exclusive; at most one is high in any cycle.

Optional Feature:
- Macro PSRAM_ARB_AGING_EN.
- Defined: a counter increments each cycle vid_req is pending and not granted, and clears on video grant. When it reaches VID_MAX_WAIT, video outranks CPU at the next IDLE grant.
- Undefined: strict CPU > video > DMA; the counter is not built.

Test Plan:
- cpu_wr addr=0x000102, din=0xBEEF, byte=0 with model busy of 8 cycles -> one m_write pulse, m_addr=0x000102, m_din=0xBEEF, cpu_ack 1 cycle after busy falls; then cpu_rd same addr -> cpu_ack with rdata[15:0]=0xBEEF.
- vid_req addr=0x000043 -> m_rdv pulse, m_addr=0x000040; model returns 0x11223344 -> vid_ack with rdata=0x11223344.
- cpu_rd, vid_req and dma_req all asserted in the same cycle -> grant order CPU, video, DMA; three acks, never overlapping.
- m_busy held high (init) for 200 cycles with cpu_rd pending -> no strobe until busy drops, then normal ack. Separately, model never raises busy -> err=1 and cpu_ack with rdata=0 after 4 cycles.
- With PSRAM_ARB_AGING_EN, continuous back-to-back cpu_rd plus vid_req -> video granted within 24+op cycles. Without the macro, video starves until CPU stops.
- Reset asserted during WAIT_DONE -> all acks and strobes 0 immediately, FSM IDLE, no spurious ack after release.
